// File: rtl/aes_word_master.sv
// Word-serial front end for a 32-bit cipher port: loads a 128-bit key/text
// as four words, then collects four result words into one ciphertext block.
module aes_word_master #(
  parameter int TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_i,
  input  logic [127:0] key_i,
  input  logic [127:0] text_i,
  output logic         busy_o,
  output logic         ld_o,
  output logic [31:0]  key_o,
  output logic [31:0]  text_o,
  input  logic         aes_done_i,
  input  logic [31:0]  aes_word_i,
  output logic [127:0] result_o,
  output logic         result_valid_o,
  output logic         timeout_o
);

  // Handshake: start_i is a request sampled only while IDLE; ld_o and
  // aes_done_i are single-cycle strobes with no backpressure in either direction.

  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;

  state_t         state_q, state_d;
  logic [1:0]     beat_q, beat_d;
  logic [1:0]     coll_q, coll_d;
  logic [TW-1:0]  tmo_q, tmo_d;
  logic [127:0]   key_h_q, key_h_d;
  logic [127:0]   text_h_q, text_h_d;
  logic [127:0]   slots_q, slots_d;
  logic [127:0]   result_q, result_d;
  logic           busy_q, busy_d;
  logic           ld_q, ld_d;
  logic [31:0]    key_w_q, key_w_d;
  logic [31:0]    text_w_q, text_w_d;
  logic           rv_q, rv_d;
  logic           to_q, to_d;

  function automatic logic [31:0] word_sel(input logic [127:0] v, input logic [1:0] n);
    logic [31:0] w;
    case (n)
      2'd0:    w = v[127:96];
      2'd1:    w = v[95:64];
      2'd2:    w = v[63:32];
      default: w = v[31:0];
    endcase
    return w;
  endfunction

  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    coll_d   = coll_q;
    tmo_d    = tmo_q;
    key_h_d  = key_h_q;
    text_h_d = text_h_q;
    slots_d  = slots_q;
    result_d = result_q;
    ld_d     = 1'b0;
    key_w_d  = 32'd0;
    text_w_d = 32'd0;
    rv_d     = 1'b0;
    to_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          key_h_d  = key_i;
          text_h_d = text_i;
          beat_d   = 2'd0;
          state_d  = SEND;
          ld_d     = 1'b1;
          key_w_d  = key_i[127:96];
          text_w_d = text_i[127:96];
        end
      end
      SEND: begin
        if (beat_q == 2'd3) begin
          state_d = WAIT;
          coll_d  = 2'd0;
          tmo_d   = '0;
        end else begin
          // Output words are registered, so present the next beat's word now.
          beat_d   = beat_q + 2'd1;
          ld_d     = 1'b1;
          key_w_d  = word_sel(key_h_q, beat_q + 2'd1);
          text_w_d = word_sel(text_h_q, beat_q + 2'd1);
        end
      end
      WAIT: begin
        tmo_d = tmo_q + TW'(1);
        if (aes_done_i && coll_q == 2'd3) begin
          state_d  = IDLE;
          result_d = {slots_q[127:32], aes_word_i};
          rv_d     = 1'b1;
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          state_d = IDLE;
          coll_d  = 2'd0;
          slots_d = '0;
          to_d    = 1'b1;
        end else if (aes_done_i) begin
          coll_d = coll_q + 2'd1;
          case (coll_q)
            2'd0:    slots_d[127:96] = aes_word_i;
            2'd1:    slots_d[95:64]  = aes_word_i;
            default: slots_d[63:32]  = aes_word_i;
          endcase
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      beat_q   <= 2'd0;
      coll_q   <= 2'd0;
      tmo_q    <= '0;
      key_h_q  <= '0;
      text_h_q <= '0;
      slots_q  <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      ld_q     <= 1'b0;
      key_w_q  <= 32'd0;
      text_w_q <= 32'd0;
      rv_q     <= 1'b0;
      to_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      coll_q   <= coll_d;
      tmo_q    <= tmo_d;
      key_h_q  <= key_h_d;
      text_h_q <= text_h_d;
      slots_q  <= slots_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      ld_q     <= ld_d;
      key_w_q  <= key_w_d;
      text_w_q <= text_w_d;
      rv_q     <= rv_d;
      to_q     <= to_d;
    end
  end

  assign busy_o         = busy_q;
  assign ld_o           = ld_q;
  assign key_o          = key_w_q;
  assign text_o         = text_w_q;
  assign result_o       = result_q;
  assign result_valid_o = rv_q;
  assign timeout_o      = to_q;

endmodule
